button_debouncer: RTL and testbench

- Cleans raw push-button inputs before they reach the player controller and AI controller.
- Each button passes through a two-flop synchroniser, then a per-button debounce state machine.
- The state machine commits a level change only after the input has been stable for DEBOUNCE_TICKS consecutive debounce ticks.
- The debounce tick is the once-per-line-group pulse from graphics_top (rising edge of vpos bit 5). The block outputs debounced levels plus one-cycle press and release pulses.

---
 rtl/dino_input_pkg.sv | 18 +
 rtl/debounce_channel.sv | 115 +++++++++++
 rtl/button_debouncer.sv | 34 +++
 tb/tb_button_debouncer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_input_pkg.sv
// Shared encodings and widths for the button input path (debounce channels and top).
package dino_input_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED        = 2'd0,
    ST_PRESS_PENDING   = 2'd1,
    ST_PRESSED         = 2'd2,
    ST_RELEASE_PENDING = 2'd3
  } state_t;

  localparam int CNT_W  = 4;
  localparam int RCNT_W = 8;

  localparam int BTN_START = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 2;

endpackage

// File: rtl/debounce_channel.sv
// One button: two-flop synchroniser followed by a tick-counted debounce FSM.
// Define BUTTON_AUTOREPEAT_EN to add periodic press pulses while the button is held.
module debounce_channel
  import dino_input_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int REPEAT_TICKS   = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15 || REPEAT_TICKS < 1 || REPEAT_TICKS > 255) begin : g_bad_cfg
    $error("debounce_channel: DEBOUNCE_TICKS or REPEAT_TICKS out of range");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_TICKS - 1);

  logic                meta;
  logic                sync;
  state_t              state;
  logic [CNT_W-1:0]    cnt;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(REPEAT_TICKS - 1);
  logic [RCNT_W-1:0]   rcnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
    end
  end

  // An input change that disagrees with the pending direction aborts before any tick is counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RELEASED;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rcnt          <= '0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        ST_RELEASED: begin
          if (sync) begin
            state <= ST_PRESS_PENDING;
            cnt   <= CNT_LOAD;
          end
        end
        ST_PRESS_PENDING: begin
          if (!sync) begin
            state <= ST_RELEASED;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == '0) begin
              state       <= ST_PRESSED;
              level       <= 1'b1;
              press_pulse <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
              rcnt        <= RCNT_LOAD;
`endif
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        ST_PRESSED: begin
          if (!sync) begin
            state <= ST_RELEASE_PENDING;
            cnt   <= CNT_LOAD;
          end
`ifdef BUTTON_AUTOREPEAT_EN
          if (tick) begin
            if (rcnt == '0) begin
              press_pulse <= 1'b1;
              rcnt        <= RCNT_LOAD;
            end else begin
              rcnt <= rcnt - RCNT_W'(1);
            end
          end
`endif
        end
        ST_RELEASE_PENDING: begin
          if (sync) begin
            state <= ST_PRESSED;
          end else if (tick) begin
            if (cnt == '0) begin
              state         <= ST_RELEASED;
              level         <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        default: state <= ST_RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BUTTONS raw push-buttons (start/up/down) using the line-group tick.
// Auto-repeat press pulses are enabled by defining BUTTON_AUTOREPEAT_EN.
module button_debouncer
  import dino_input_pkg::*;
#(
  parameter int NUM_BUTTONS    = 3,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int REPEAT_TICKS   = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_tick,
  input  logic [NUM_BUTTONS-1:0] i_btn_raw,
  output logic [NUM_BUTTONS-1:0] o_btn_level,
  output logic [NUM_BUTTONS-1:0] o_btn_press,
  output logic [NUM_BUTTONS-1:0] o_btn_release
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .tick         (i_tick),
      .btn          (i_btn_raw[i]),
      .level        (o_btn_level[i]),
      .press_pulse  (o_btn_press[i]),
      .release_pulse(o_btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: tick every 16 clocks, DEBOUNCE_TICKS=3, REPEAT_TICKS=4.
module tb_button_debouncer;
  import dino_input_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_tick;
  logic [2:0] i_btn_raw;
  logic [2:0] o_btn_level;
  logic [2:0] o_btn_press;
  logic [2:0] o_btn_release;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ticks = 0;
  int press_cnt [3];
  int rel_cnt [3];
  bit overlap = 1'b0;

  typedef struct {
    logic [2:0] raw;
    int         periods;
    logic [2:0] level;
    logic [2:0] press;
    logic [2:0] rel;
  } vec_t;

  always #5 clk = ~clk;

  button_debouncer #(
    .NUM_BUTTONS   (3),
    .DEBOUNCE_TICKS(3),
    .REPEAT_TICKS  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_tick       (i_tick),
    .i_btn_raw    (i_btn_raw),
    .o_btn_level  (o_btn_level),
    .o_btn_press  (o_btn_press),
    .o_btn_release(o_btn_release)
  );

  // One clock edge; outputs are sampled 1 ns after it and the tick for the next edge is set.
  task automatic step();
    logic t;
    t = i_tick;
    @(posedge clk);
    #1;
    cyc++;
    if (t) ticks++;
    for (int i = 0; i < 3; i++) begin
      if (o_btn_press[i]) press_cnt[i]++;
      if (o_btn_release[i]) rel_cnt[i]++;
    end
    if ((o_btn_press & o_btn_release) != 3'b000) overlap = 1'b1;
    i_tick = (cyc % 16 == 15);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic alignTo(input int phase);
    while (cyc % 16 != phase) step();
  endtask

  task automatic clearCounts();
    for (int i = 0; i < 3; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i] = 0;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] raw);
    i_btn_raw = raw;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int packCounts(input int c2, input int c1, input int c0);
    return c2 * 100 + c1 * 10 + c0;
  endfunction

  // Raises one button at a known tick phase and checks the commit lands on the 3rd tick.
  task automatic pressTimed(input int ch, input string name);
    int  t0;
    bit  seen;
    bit  early;
    seen = 1'b0;
    early = 1'b0;
    clearCounts();
    alignTo(0);
    i_btn_raw[ch] = 1'b1;
    run(3);
    t0 = ticks;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      if (o_btn_press[ch]) seen = 1'b1;
      else if (o_btn_level[ch]) early = 1'b1;
    end
    checkOutput({name, " press seen"}, int'(seen), 1);
    checkOutput({name, " commit tick"}, ticks - t0, 3);
    checkOutput({name, " early level"}, int'(early), 0);
    run(20);
    checkOutput({name, " level held"}, int'(o_btn_level[ch]), 1);
    checkOutput({name, " press count"}, press_cnt[ch], 1);
  endtask

  task automatic releaseAll();
    clearCounts();
    applyStimulus(3'b000);
    run(80);
    checkOutput("release all level", int'(o_btn_level), 0);
  endtask

  initial begin
    vec_t tbl [10];
    int   t0;
    bit   seen;

    tbl[0] = '{3'b001, 4, 3'b001, 3'b001, 3'b000};
    tbl[1] = '{3'b011, 4, 3'b011, 3'b010, 3'b000};
    tbl[2] = '{3'b010, 4, 3'b010, 3'b000, 3'b001};
    tbl[3] = '{3'b110, 2, 3'b010, 3'b000, 3'b000};
    tbl[4] = '{3'b100, 4, 3'b100, 3'b100, 3'b010};
    tbl[5] = '{3'b000, 1, 3'b100, 3'b000, 3'b000};
    tbl[6] = '{3'b100, 4, 3'b100, 3'b000, 3'b000};
    tbl[7] = '{3'b000, 4, 3'b000, 3'b000, 3'b100};
    tbl[8] = '{3'b111, 2, 3'b000, 3'b000, 3'b000};
    tbl[9] = '{3'b000, 4, 3'b000, 3'b000, 3'b000};

    rst = 1'b1;
    i_tick = 1'b0;
    applyStimulus(3'b111);
    clearCounts();

    // Reset held with all buttons pressed.
    run(4);
    checkOutput("reset level", int'(o_btn_level), 0);
    checkOutput("reset press", int'(o_btn_press), 0);
    checkOutput("reset release", int'(o_btn_release), 0);
    alignTo(0);
    rst = 1'b0;
    clearCounts();
    run(3);
    t0 = ticks;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      if (o_btn_press[BTN_START]) seen = 1'b1;
    end
    checkOutput("post-reset press seen", int'(seen), 1);
    checkOutput("post-reset commit tick", ticks - t0, 3);
    run(20);
    checkOutput("post-reset level", int'(o_btn_level[BTN_START]), 1);
    checkOutput("post-reset press count", press_cnt[BTN_START], 1);
    releaseAll();

`ifndef BUTTON_AUTOREPEAT_EN
    for (int r = 0; r < 10; r++) begin
      clearCounts();
      applyStimulus(tbl[r].raw);
      run(tbl[r].periods * 16);
      checkOutput($sformatf("row%0d level", r), int'(o_btn_level), int'(tbl[r].level));
      checkOutput($sformatf("row%0d press", r), packCounts(press_cnt[2], press_cnt[1], press_cnt[0]),
                  packCounts(int'(tbl[r].press[2]), int'(tbl[r].press[1]), int'(tbl[r].press[0])));
      checkOutput($sformatf("row%0d release", r), packCounts(rel_cnt[2], rel_cnt[1], rel_cnt[0]),
                  packCounts(int'(tbl[r].rel[2]), int'(tbl[r].rel[1]), int'(tbl[r].rel[0])));
    end
`endif

    pressTimed(BTN_UP, "clean press");
    clearCounts();
    i_btn_raw[BTN_UP] = 1'b0;
    run(64);
    checkOutput("clean release pulse", rel_cnt[BTN_UP], 1);
    checkOutput("clean release level", int'(o_btn_level[BTN_UP]), 0);

    // Bounce: rise, drop (aborted by a tick-coincident low), final rise held.
    clearCounts();
    alignTo(8);
    i_btn_raw[BTN_DOWN] = 1'b1;
    run(5);
    i_btn_raw[BTN_DOWN] = 1'b0;
    run(5);
    i_btn_raw[BTN_DOWN] = 1'b1;
    run(3);
    t0 = ticks;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      if (o_btn_press[BTN_DOWN]) seen = 1'b1;
    end
    checkOutput("bounce press seen", int'(seen), 1);
    checkOutput("bounce commit tick", ticks - t0, 3);
    run(20);
    checkOutput("bounce press count", press_cnt[BTN_DOWN], 1);
    releaseAll();

    // Abort vs tick: input goes low exactly when the final tick arrives.
    clearCounts();
    alignTo(0);
    i_btn_raw[BTN_START] = 1'b1;
    run(3);
    t0 = ticks;
    for (int k = 0; k < 100 && (ticks - t0) < 2; k++) step();
    checkOutput("abort pending ticks", ticks - t0, 2);
    alignTo(13);
    i_btn_raw[BTN_START] = 1'b0;
    run(48);
    checkOutput("abort press count", press_cnt[BTN_START], 0);
    checkOutput("abort level", int'(o_btn_level[BTN_START]), 0);
    pressTimed(BTN_START, "re-press after abort");
    releaseAll();

`ifdef BUTTON_AUTOREPEAT_EN
    clearCounts();
    alignTo(0);
    i_btn_raw[BTN_UP] = 1'b1;
    run(3);
    t0 = ticks;
    for (int k = 0; k < 400 && (ticks - t0) < 20; k++) step();
    checkOutput("repeat hold ticks", ticks - t0, 20);
    i_btn_raw[BTN_UP] = 1'b0;
    run(80);
    checkOutput("repeat press count", press_cnt[BTN_UP], 5);
    checkOutput("repeat release count", rel_cnt[BTN_UP], 1);
    checkOutput("repeat final level", int'(o_btn_level[BTN_UP]), 0);
`endif

    checkOutput("press and release never together", int'(overlap), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
